lock_sequencer: RTL

Sequencing controller for the six-digit combination lock. It accepts BCD digits from the switches on a one-cycle `enter` strobe and checks them against a stored, reprogrammable passcode. It counts failed attempts and enforces a timed lockout. It drives mode and status signals that the seven-segment display encoder turns into digit, "ErrOr", "OPEn", "CLOSEd", lockout and program glyphs.

---
 rtl/lock_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lock_sequencer.sv
// lock_sequencer: sequencing controller for a BCD combination lock.
// It collects CODE_LEN digits on `enter` strobes and compares them with a
// stored passcode, which can be reprogrammed from OPEN. It counts
// consecutive failed attempts and enforces a timed lockout, and it
// produces the mode code that the seven-segment encoder turns into glyphs.
module lock_sequencer #(
    parameter int          CODE_LEN       = 6,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 1000,
    parameter logic [31:0] DEFAULT_CODE   = 32'h00632914
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sw,
    input  logic       enter,
    input  logic       relock,
    input  logic       prog,
    output logic       unlocked,
    output logic       locked_out,
    output logic [2:0] disp_mode,
    output logic [2:0] idx,
    output logic [1:0] fail_cnt,
    output logic       code_err
);

    // The timer is loaded with LOCKOUT_CYCLES-1 and counts down to zero.
    localparam int              TW         = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]      LAST_IDX   = 3'(CODE_LEN - 1);
    localparam logic [1:0]      FAIL_LIMIT = 2'(MAX_FAILS);

    // Display mode codes understood by the seven-segment encoder.
    localparam logic [2:0] DISP_DIGIT   = 3'd0;
    localparam logic [2:0] DISP_ERROR   = 3'd1;
    localparam logic [2:0] DISP_OPEN    = 3'd2;
    localparam logic [2:0] DISP_CLOSED  = 3'd3;
    localparam logic [2:0] DISP_LOCKOUT = 3'd4;
    localparam logic [2:0] DISP_PROG    = 3'd5;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_CLOSED,
        ST_LOCKOUT,
        ST_PROGRAM
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_d;
    logic          mismatch_q, mismatch_d;
    logic [1:0]    fail_d;
    logic          code_err_d;
    logic [31:0]   code_q, code_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [TW-1:0] timer_q, timer_d;

    // Digit decode helpers shared by the entry and program paths.
    logic          sw_valid;
    logic [3:0]    digit;
    logic [2:0]    nib_pos;
    logic [3:0]    code_digit;
    logic          digit_wrong;
    logic          attempt_bad;
    logic          is_last;
    logic [1:0]    fail_inc;
    logic [31:0]   shadow_wr;

    assign sw_valid    = (sw <= 10'd9);
    assign digit       = sw[3:0];
    // Digit 0 lives in the most significant used nibble.
    assign nib_pos     = LAST_IDX - idx;
    assign code_digit  = code_q[{nib_pos, 2'b00} +: 4];
    assign digit_wrong = (digit != code_digit);
    // The verdict includes the digit being entered right now.
    assign attempt_bad = mismatch_q | digit_wrong;
    assign is_last     = (idx == LAST_IDX);
    assign fail_inc    = fail_cnt + 2'd1;

    // Shadow code with the current digit written in, used for both the
    // incremental write and the one-cycle commit on the last digit.
    always_comb begin
        shadow_wr = shadow_q;
        shadow_wr[{nib_pos, 2'b00} +: 4] = digit;
    end

    // Next-state and next-field logic for the sequencer.
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx;
        mismatch_d = mismatch_q;
        fail_d     = fail_cnt;
        code_d     = code_q;
        shadow_d   = shadow_q;
        timer_d    = timer_q;
        code_err_d = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (enter) begin
                    if (!sw_valid) begin
                        code_err_d = 1'b1;
                    end else if (!is_last) begin
                        // Keep checking after a wrong digit so the failing
                        // position is never revealed.
                        mismatch_d = attempt_bad;
                        idx_d      = idx + 3'd1;
                    end else begin
                        idx_d      = 3'd0;
                        mismatch_d = 1'b0;
                        if (!attempt_bad) begin
                            state_d = ST_OPEN;
                            fail_d  = 2'd0;
                        end else if (fail_inc < FAIL_LIMIT) begin
                            state_d = ST_CLOSED;
                            fail_d  = fail_inc;
                        end else begin
                            state_d = ST_LOCKOUT;
                            timer_d = TIMER_LOAD;
                            fail_d  = FAIL_LIMIT;
                        end
                    end
                end
            end

            ST_CLOSED: begin
                // Acknowledgement press only; sw is not consumed.
                if (enter) begin
                    state_d = ST_ENTRY;
                end
            end

            ST_OPEN: begin
                if (relock) begin
                    state_d = ST_ENTRY;
                end else if (prog) begin
                    state_d = ST_PROGRAM;
                    idx_d   = 3'd0;
                end
            end

            ST_PROGRAM: begin
                if (relock) begin
                    // Abort: drop the partial shadow, stored code untouched.
                    state_d  = ST_ENTRY;
                    idx_d    = 3'd0;
                    shadow_d = '0;
                end else if (enter) begin
                    if (!sw_valid) begin
                        code_err_d = 1'b1;
                    end else if (!is_last) begin
                        shadow_d = shadow_wr;
                        idx_d    = idx + 3'd1;
                    end else begin
                        code_d   = shadow_wr;
                        shadow_d = shadow_wr;
                        idx_d    = 3'd0;
                        state_d  = ST_OPEN;
                    end
                end
            end

            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                    fail_d  = 2'd0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: begin
                state_d = ST_ENTRY;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State register and all registered outputs.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    // NOTE: the passcode registers are reset too: a reset must restore
    // DEFAULT_CODE and drop any partial reprogramming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ENTRY;
            idx        <= 3'd0;
            mismatch_q <= 1'b0;
            fail_cnt   <= 2'd0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            code_err   <= 1'b0;
            code_q     <= DEFAULT_CODE;
            shadow_q   <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx        <= idx_d;
            mismatch_q <= mismatch_d;
            fail_cnt   <= fail_d;
            unlocked   <= (state_d == ST_OPEN);
            locked_out <= (state_d == ST_LOCKOUT);
            code_err   <= code_err_d;
            code_q     <= code_d;
            shadow_q   <= shadow_d;
            timer_q    <= timer_d;
        end
    end

    // Display mode follows the current state and sw within the cycle.
    always_comb begin
        disp_mode = DISP_DIGIT;
        case (state_q)
            ST_ENTRY:   disp_mode = sw_valid ? DISP_DIGIT : DISP_ERROR;
            ST_PROGRAM: disp_mode = sw_valid ? DISP_PROG  : DISP_ERROR;
            ST_OPEN:    disp_mode = DISP_OPEN;
            ST_CLOSED:  disp_mode = DISP_CLOSED;
            ST_LOCKOUT: disp_mode = DISP_LOCKOUT;
            default:    disp_mode = DISP_ERROR;
        endcase
    end

endmodule
